uart_alu_parser: RTL and testbench
==================================

# uart_alu_parser

Front-end packet parser for the UART ALU. It consumes the byte stream from `uart_rx`, decodes the 4-byte packet header (opcode, reserved, length LSB, length MSB) and assembles the payload into little-endian 32-bit operand words. It presents those words, tagged with opcode and first/last flags, on a ready/valid word interface to the ALU compute stage. Malformed packets are flagged and discarded without stalling the link.

## Interface
- `OP_ECHO`, default 8'hEC: opcode value accepted as echo.
- `OP_ADD`, default 8'h01: opcode value accepted as add.
- `clk_i` input 1: system clock.
- `reset_i` input 1: asynchronous, active-high reset.
- `s_tdata_i` input 8: received byte from `uart_rx`.
- `s_tvalid_i` input 1: byte valid.
- `s_tready_o` output 1: byte accepted when `s_tvalid_i & s_tready_o` at a rising edge.
- `m_tdata_o` output 32: assembled operand word.
- `m_opcode_o` output 8: opcode of the current packet; stable for the whole packet.
- `m_first_o` output 1: the word is the first of its packet.
- `m_last_o` output 1: the word is the last of its packet.
- `m_tvalid_o` output 1: word valid.
- `m_tready_i` input 1: downstream accepts the word.
- `err_o` output 1: one-cycle pulse when a packet is rejected.

## Operation
- States: `HDR_OP`, `HDR_RSV`, `HDR_LLO`, `HDR_LHI`, `PAYLOAD`, `DISCARD`. Each accepted byte advances the state.
- `HDR_OP`: latch the opcode and go to `HDR_RSV`.
- `HDR_RSV`: ignore the byte and go to `HDR_LLO`.
- `HDR_LLO`: latch `len[7:0]` and go to `HDR_LHI`.
- `HDR_LHI`: form `len` = {byte, `len[7:0]`}. `len` is the total packet length including the 4 header bytes. `remaining` = `len - 4`, held in a 16-bit register.
- Validity check, evaluated on the `HDR_LHI` byte:
  - Valid requires: opcode is `OP_ECHO` or `OP_ADD`, `len >= 8`, and `len[1:0] == 0`.
  - Valid: go to `PAYLOAD`, byte index = 0, first flag = 1.
  - Invalid: pulse `err_o`. If `len > 4`, go to `DISCARD`; otherwise go to `HDR_OP`.
  - When `len < 4`, `remaining` is forced to 0. It never wraps.
- `PAYLOAD`:
  - Byte k of each word goes to `m_tdata_o[8k+7:8k]`; k = 0 is the first byte received.
  - Each accepted byte decrements `remaining`.
  - On the 4th byte, load the output register: `m_tvalid_o` = 1, `m_first_o` = first flag, `m_last_o` = (`remaining` after decrement == 0). Then clear the first flag.
  - If that word was last, go to `HDR_OP`; otherwise stay in `PAYLOAD`.
- `DISCARD`: accept and drop `remaining` bytes, then go to `HDR_OP`. No words are produced.
- Output register: one entry. `m_tvalid_o` clears on the cycle after `m_tvalid_o & m_tready_i`.
- `s_tready_o` = `~reset_i & ~m_tvalid_o`, in every state. Header bytes of the next packet therefore wait until the last word of the previous packet is consumed.
- Reset, asynchronous, at any point including mid-packet:
  - State = `HDR_OP`, and all counters and flags are cleared.
  - `m_tvalid_o`, `m_first_o`, `m_last_o`, `err_o` = 0.
  - `m_tdata_o` = 0, `m_opcode_o` = 0, `s_tready_o` = 0 while `reset_i` is high and 1 after release.
  - A partially received packet is lost. Parsing restarts at the next byte, which is treated as an opcode.

## Timing
- Word latency: `m_tvalid_o` rises at the edge that accepts the 4th byte of the word, so it is visible in the following cycle.
- Backpressure: while `m_tvalid_o` = 1 and `m_tready_i` = 0:
  - `m_tdata_o`, `m_first_o`, `m_last_o` and `m_opcode_o` hold stable.
  - `s_tready_o` = 0.
- Throughput: with `m_tready_i` tied high, at most 4 bytes are accepted per 5 cycles (one bubble per word). This far exceeds the UART byte rate.
- `err_o`: registered, high for exactly one cycle, the cycle after the `HDR_LHI` byte is accepted.
- No combinational path from `s_tvalid_i` to `m_tvalid_o`. `s_tready_o` depends only on registers and `reset_i`.

## Test plan
- Add packet: 01 00 0C 00 44 33 22 11 05 00 00 00 -> two words, all with `m_opcode_o` = 8'h01:
  - 32'h11223344, first = 1, last = 0.
  - 32'h00000005, first = 0, last = 1.
- Echo packet: EC 00 08 00 DE AD BE EF -> one word 32'hEFBEADDE, first = 1, last = 1, opcode 8'hEC.
- Backpressure: add packet with 3 operands, `m_tready_i` = 0 for 20 cycles at the first word:
  - `m_tvalid_o` and data stay stable and `s_tready_o` = 0 for all 20 cycles.
  - All 3 words are then delivered in order.
- Bad length: 01 00 0A 00 followed by 6 bytes, then a valid echo packet:
  - One `err_o` pulse and no `m_tvalid_o` for the bad packet.
  - The echo word is delivered correctly.
- Unknown opcode, then short length:
  - 55 00 08 00 AA BB CC DD -> `err_o` pulse, 4 bytes discarded.
  - 01 00 02 00 -> `err_o` pulse, immediate return to `HDR_OP`.
  - A following add packet parses correctly.
- Reset mid-payload: assert `reset_i` after 2 payload bytes:
  - All outputs are 0 immediately.
  - After release, a fresh echo packet yields the correct word.

Source files
------------

// File: rtl/uart_alu_parser.sv
// Packet parser: 4-byte header (opcode, reserved, len lo, len hi) then payload
// packed little-endian into 32-bit words. Word valid the cycle after its 4th byte.
// Backpressure: byte input stalls (s_tready_o low) while an output word is pending.
module uart_alu_parser #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'h01
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  output logic [31:0] m_tdata_o,
  output logic [7:0]  m_opcode_o,
  output logic        m_first_o,
  output logic        m_last_o,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic        err_o
);

  typedef enum logic [2:0] {
    HDR_OP, HDR_RSV, HDR_LLO, HDR_LHI, PAYLOAD, DISCARD
  } state_t;

  state_t      state_q;
  logic [7:0]  opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] remaining_q;
  logic [1:0]  byte_idx_q;
  logic        first_q;
  logic [23:0] word_q;
  logic [31:0] m_tdata_q;
  logic        m_tvalid_q;
  logic        m_first_q;
  logic        m_last_q;
  logic        err_q;

  logic        accept_d;
  logic [15:0] len_d;
  logic        hdr_ok_d;
  logic [15:0] rem_dec_d;

  // Handshake and header decode helpers; ready depends only on registers and reset.
  always_comb begin
    s_tready_o = ~reset_i & ~m_tvalid_q;
    accept_d   = s_tvalid_i & s_tready_o;
    len_d      = {s_tdata_i, len_lo_q};
    hdr_ok_d   = ((opcode_q == OP_ECHO) || (opcode_q == OP_ADD)) &&
                 (len_d >= 16'd8) && (len_d[1:0] == 2'b00);
    rem_dec_d  = remaining_q - 16'd1;
  end

  // Parser FSM with registered word, flag and error outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= HDR_OP;
      opcode_q    <= 8'h00;
      len_lo_q    <= 8'h00;
      remaining_q <= 16'h0000;
      byte_idx_q  <= 2'd0;
      first_q     <= 1'b0;
      word_q      <= 24'h000000;
      m_tdata_q   <= 32'h0;
      m_tvalid_q  <= 1'b0;
      m_first_q   <= 1'b0;
      m_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // Output entry frees on handshake; a new byte cannot arrive in the same cycle.
      if (m_tvalid_q && m_tready_i) begin
        m_tvalid_q <= 1'b0;
      end
      if (accept_d) begin
        case (state_q)
          HDR_OP: begin
            opcode_q <= s_tdata_i;
            state_q  <= HDR_RSV;
          end
          HDR_RSV: state_q <= HDR_LLO;
          HDR_LLO: begin
            len_lo_q <= s_tdata_i;
            state_q  <= HDR_LHI;
          end
          HDR_LHI: begin
            // Length counts the header; clamp so a short length never wraps.
            remaining_q <= (len_d < 16'd4) ? 16'h0000 : (len_d - 16'd4);
            byte_idx_q  <= 2'd0;
            if (hdr_ok_d) begin
              first_q <= 1'b1;
              state_q <= PAYLOAD;
            end else begin
              err_q   <= 1'b1;
              state_q <= (len_d > 16'd4) ? DISCARD : HDR_OP;
            end
          end
          PAYLOAD: begin
            remaining_q <= rem_dec_d;
            byte_idx_q  <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= s_tdata_i;
              2'd1: word_q[15:8]  <= s_tdata_i;
              2'd2: word_q[23:16] <= s_tdata_i;
              default: begin
                m_tdata_q  <= {s_tdata_i, word_q};
                m_tvalid_q <= 1'b1;
                m_first_q  <= first_q;
                m_last_q   <= (rem_dec_d == 16'h0000);
                first_q    <= 1'b0;
                if (rem_dec_d == 16'h0000) begin
                  state_q <= HDR_OP;
                end
              end
            endcase
          end
          DISCARD: begin
            remaining_q <= rem_dec_d;
            if (rem_dec_d == 16'h0000) begin
              state_q <= HDR_OP;
            end
          end
          default: state_q <= HDR_OP;
        endcase
      end
    end
  end

  assign m_tdata_o  = m_tdata_q;
  assign m_opcode_o = opcode_q;
  assign m_first_o  = m_first_q;
  assign m_last_o   = m_last_q;
  assign m_tvalid_o = m_tvalid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_alu_parser.sv
// Directed bench for uart_alu_parser: header decode, word packing, backpressure,
// malformed-packet rejection and mid-packet reset.
module tb_uart_alu_parser;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  s_tdata_i = 8'h00;
  logic        s_tvalid_i = 1'b0;
  logic        s_tready_o;
  logic [31:0] m_tdata_o;
  logic [7:0]  m_opcode_o;
  logic        m_first_o;
  logic        m_last_o;
  logic        m_tvalid_o;
  logic        m_tready_i = 1'b1;
  logic        err_o;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;

  logic [31:0] wq_dat[$];
  logic [7:0]  wq_op[$];
  logic        wq_first[$];
  logic        wq_last[$];

  uart_alu_parser #(.OP_ECHO(8'hEC), .OP_ADD(8'h01)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_opcode_o(m_opcode_o), .m_first_o(m_first_o),
    .m_last_o(m_last_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Record every completed word handshake and every error cycle, mid-cycle.
  always @(negedge clk) begin
    if (!reset_i && m_tvalid_o && m_tready_i) begin
      wq_dat.push_back(m_tdata_o);
      wq_op.push_back(m_opcode_o);
      wq_first.push_back(m_first_o);
      wq_last.push_back(m_last_o);
    end
    if (err_o) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_tdata_i  = b;
    s_tvalid_i = 1'b1;
    while (!s_tready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready_o) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%0d expected=<200", n);
    end
    @(posedge clk);
    #1;
    s_tvalid_i = 1'b0;
  endtask

  task automatic send4(input logic [31:0] v);
    send_byte(v[31:24]);
    send_byte(v[23:16]);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic chk_word(input string tag, input int i, input logic [31:0] d,
                          input logic [7:0] op, input logic f, input logic l);
    chk({tag, "_dat"}, wq_dat[i], d);
    chk({tag, "_op"}, {24'h0, wq_op[i]}, {24'h0, op});
    chk({tag, "_first"}, {31'h0, wq_first[i]}, {31'h0, f});
    chk({tag, "_last"}, {31'h0, wq_last[i]}, {31'h0, l});
  endtask

  initial begin
    int base_w;
    int base_e;

    // Reset state
    tick(2);
    chk("rst_tvalid", {31'h0, m_tvalid_o}, 32'h0);
    chk("rst_tready", {31'h0, s_tready_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_tdata", m_tdata_o, 32'h0);
    chk("rst_opcode", {24'h0, m_opcode_o}, 32'h0);
    reset_i = 1'b0;
    #1;
    chk("rel_tready", {31'h0, s_tready_o}, 32'h1);

    // Add packet: two words
    send4(32'h01000C00);
    send4(32'h44332211);
    send4(32'h05000000);
    tick(4);
    chk("add_count", wq_dat.size(), 32'd2);
    chk_word("add_w0", 0, 32'h11223344, 8'h01, 1'b1, 1'b0);
    chk_word("add_w1", 1, 32'h00000005, 8'h01, 1'b0, 1'b1);

    // Echo packet: one word, first and last
    send4(32'hEC000800);
    send4(32'hDEADBEEF);
    tick(4);
    chk("echo_count", wq_dat.size(), 32'd3);
    chk_word("echo_w", 2, 32'hEFBEADDE, 8'hEC, 1'b1, 1'b1);

    // Backpressure: stall the first of three words for 20 cycles
    m_tready_i = 1'b0;
    send4(32'h01001000);
    send4(32'h10203040);
    for (int c = 0; c < 20; c++) begin
      chk("bp_tvalid", {31'h0, m_tvalid_o}, 32'h1);
      chk("bp_tdata", m_tdata_o, 32'h40302010);
      chk("bp_tready", {31'h0, s_tready_o}, 32'h0);
      tick(1);
    end
    chk("bp_first_hold", {30'h0, m_first_o, m_last_o}, 32'h2);
    m_tready_i = 1'b1;
    send4(32'h55667788);
    send4(32'h01000080);
    tick(4);
    chk("bp_count", wq_dat.size(), 32'd6);
    chk_word("bp_w0", 3, 32'h40302010, 8'h01, 1'b1, 1'b0);
    chk_word("bp_w1", 4, 32'h88776655, 8'h01, 1'b0, 1'b0);
    chk_word("bp_w2", 5, 32'h80000001, 8'h01, 1'b0, 1'b1);

    // Bad length (10, not a multiple of 4): error, 6 bytes dropped, then echo
    base_w = wq_dat.size();
    base_e = err_cnt;
    send4(32'h01000A00);
    send4(32'hA1A2A3A4);
    send_byte(8'hA5);
    send_byte(8'hA6);
    tick(2);
    chk("badlen_err", err_cnt - base_e, 32'd1);
    chk("badlen_nowords", wq_dat.size() - base_w, 32'd0);
    send4(32'hEC000800);
    send4(32'h0BADCAFE);
    tick(4);
    chk("badlen_echo_count", wq_dat.size() - base_w, 32'd1);
    chk_word("badlen_echo", base_w, 32'hFECAAD0B, 8'hEC, 1'b1, 1'b1);

    // Unknown opcode (discard 4), short length (no discard), then a good add
    base_w = wq_dat.size();
    base_e = err_cnt;
    send4(32'h55000800);
    send4(32'hAABBCCDD);
    tick(2);
    chk("badop_err", err_cnt - base_e, 32'd1);
    send4(32'h01000200);
    tick(2);
    chk("short_err", err_cnt - base_e, 32'd2);
    chk("bad_nowords", wq_dat.size() - base_w, 32'd0);
    send4(32'h01000800);
    send4(32'h01020304);
    tick(4);
    chk("after_bad_count", wq_dat.size() - base_w, 32'd1);
    chk_word("after_bad", base_w, 32'h04030201, 8'h01, 1'b1, 1'b1);

    // Reset after two payload bytes
    base_w = wq_dat.size();
    send4(32'hEC000800);
    send_byte(8'h11);
    send_byte(8'h22);
    reset_i = 1'b1;
    #1;
    chk("mid_rst_tvalid", {31'h0, m_tvalid_o}, 32'h0);
    chk("mid_rst_flags", {29'h0, m_first_o, m_last_o, err_o}, 32'h0);
    chk("mid_rst_tdata", m_tdata_o, 32'h0);
    chk("mid_rst_opcode", {24'h0, m_opcode_o}, 32'h0);
    chk("mid_rst_tready", {31'h0, s_tready_o}, 32'h0);
    tick(2);
    reset_i = 1'b0;
    tick(1);
    send4(32'hEC000800);
    send4(32'h01234567);
    tick(4);
    chk("post_rst_count", wq_dat.size() - base_w, 32'd1);
    chk_word("post_rst", base_w, 32'h67452301, 8'hEC, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
